// File: rtl/uart_cam_pkg.sv
// Shared types and constants for the camera frame UART dump path.
// Frame geometry, default command bytes and the streamer state encoding.
package uart_cam_pkg;

  localparam int FRAME_W     = 160;
  localparam int FRAME_H     = 120;
  localparam int FRAME_BYTES = FRAME_W * FRAME_H;

  localparam logic [7:0] START_CMD_DEF = 8'h53;
  localparam logic [7:0] ABORT_CMD_DEF = 8'h58;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    TX_WAIT_RDY,
    TX_STROBE,
    TX_ACK,
    TX_DONE
  } state_e;

endpackage

// File: rtl/uart_tx_handshake.sv
// Per-byte strobe/ready handshake towards the UART transmitter.
// Owns the strobe counter and the abort-at-byte-boundary flag.
module uart_tx_handshake
  import uart_cam_pkg::*;
#(
  parameter int STROBE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic byte_go_i,
  input  logic abort_i,
  input  logic tx_ready_i,
  output logic tx_start_o,
  output logic byte_sent_o,
  output logic aborted_o
);

  localparam int CNT_W = $clog2(STROBE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(STROBE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign tx_start_o = (state_q == TX_STROBE);

  // An abort before the strobe drops the byte; later it only ends the dump.
  assign byte_sent_o =
    ((state_q == TX_WAIT_RDY) && abort_i) ||
    ((state_q == TX_DONE) && tx_ready_i);
  assign aborted_o = abort_q | abort_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    unique case (state_q)
      TX_WAIT_RDY: begin
        if (abort_i) begin
          state_d = IDLE;
          abort_d = 1'b0;
        end else if (tx_ready_i) begin
          state_d = TX_STROBE;
          cnt_d   = '0;
        end
      end
      TX_STROBE: begin
        abort_d = abort_q | abort_i;
        if (cnt_q == CNT_LAST) begin
          state_d = TX_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_ACK: begin
        abort_d = abort_q | abort_i;
        if (!tx_ready_i) begin
          state_d = TX_DONE;
        end
      end
      TX_DONE: begin
        abort_d = abort_q | abort_i;
        if (tx_ready_i) begin
          abort_d = 1'b0;
          state_d = byte_go_i ? TX_WAIT_RDY : IDLE;
        end
      end
      default: begin
        if (byte_go_i) begin
          state_d = TX_WAIT_RDY;
          abort_d = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/uart_frame_streamer.sv
// Command-driven frame RAM to UART TX dump stage.
// Optional checksum trailer byte: UART_FRAME_STREAMER_CHECKSUM_EN.
module uart_frame_streamer
  import uart_cam_pkg::*;
#(
  parameter int         ADDR_W           = 16,
  parameter int         FRAME_LEN        = FRAME_BYTES,
  parameter logic [7:0] START_CMD        = START_CMD_DEF,
  parameter logic [7:0] ABORT_CMD        = ABORT_CMD_DEF,
  parameter int         TX_STROBE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [7:0]        ram_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        txd_q, txd_d;
  logic              fd_q, fd_d;
  logic              go, sent, aborted, clr;
  logic              start_cmd, abort_cmd;

`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       trl_q, trl_d;
`endif

  assign start_cmd = rx_valid && (rx_data == START_CMD);
  assign abort_cmd = rx_valid && (rx_data == ABORT_CMD);

  uart_tx_handshake #(
    .STROBE_CYCLES(TX_STROBE_CYCLES)
  ) u_hs (
    .clk        (clk),
    .rst        (rst),
    .byte_go_i  (go),
    .abort_i    (abort_cmd),
    .tx_ready_i (tx_ready),
    .tx_start_o (tx_start),
    .byte_sent_o(sent),
    .aborted_o  (aborted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      txd_q   <= '0;
      fd_q    <= 1'b0;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
      csum_q  <= '0;
      trl_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      txd_q   <= txd_d;
      fd_q    <= fd_d;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
      csum_q  <= csum_d;
      trl_q   <= trl_d;
`endif
    end
  end

  // TX_WAIT_RDY here stands for the whole handshake phase of u_hs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    txd_d   = txd_q;
    fd_d    = 1'b0;
    go      = 1'b0;
    clr     = 1'b0;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
    csum_d  = csum_q;
    trl_d   = trl_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_cmd) begin
          state_d = RD_REQ;
          addr_d  = '0;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
          csum_d  = '0;
          trl_d   = 1'b0;
`endif
        end
      end
      RD_REQ: begin
        if (abort_cmd) clr = 1'b1;
        else state_d = RD_CAP;
      end
      RD_CAP: begin
        if (abort_cmd) begin
          clr = 1'b1;
        end else begin
          txd_d   = ram_rd_data;
          go      = 1'b1;
          state_d = TX_WAIT_RDY;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
          csum_d  = csum_q + ram_rd_data;
`endif
        end
      end
      default: begin
        if (sent) begin
          if (aborted) begin
            clr = 1'b1;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
          end else if (trl_q) begin
            fd_d    = 1'b1;
            addr_d  = '0;
            state_d = IDLE;
          end else if (addr_q == LAST_ADDR) begin
            trl_d = 1'b1;
            txd_d = csum_q;
            go    = 1'b1;
`else
          end else if (addr_q == LAST_ADDR) begin
            fd_d    = 1'b1;
            addr_d  = '0;
            state_d = IDLE;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
    endcase
    if (clr) begin
      state_d = IDLE;
      addr_d  = '0;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
      csum_d  = '0;
      trl_d   = 1'b0;
`endif
    end
  end

  assign ram_addr   = addr_q;
  assign ram_rd_en  = (state_q == RD_REQ);
  assign tx_data    = txd_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = fd_q;

endmodule

// File: tb/tb_uart_frame_streamer.sv
// Directed bench for uart_frame_streamer (FRAME_LEN=4, 3-cycle strobe).
// Honours UART_FRAME_STREAMER_CHECKSUM_EN for the trailer byte.
module tb_uart_frame_streamer;

`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam logic [7:0] EXP_B [5] =
    '{8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] ram_addr;
  logic        ram_rd_en;
  logic [7:0]  ram_rd_data = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;

  logic        rdy_m = 1'b1;
  logic        hold = 1'b0;
  int          mcnt = 0;

  logic [7:0]  bytes [$];
  int          lens [$];
  int          run = 0;
  logic        ts_prev = 1'b0;
  int          rd_cnt = 0;
  int          fd_cnt = 0;
  int          fd_bytes = 0;

  int checks = 0;
  int errors = 0;
  int b0, l0, r0, f0;

  assign tx_ready = rdy_m & ~hold;

  always #5 clk = ~clk;

  uart_frame_streamer #(
    .ADDR_W          (16),
    .FRAME_LEN       (4),
    .START_CMD       (8'h53),
    .ABORT_CMD       (8'h58),
    .TX_STROBE_CYCLES(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .ram_addr   (ram_addr),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_data(ram_rd_data),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always @(posedge clk)
    if (ram_rd_en)
      ram_rd_data <= 8'h10 * ({6'b0, ram_addr[1:0]} + 8'd1);

  // Transmitter: goes busy 2 cycles into a strobe, idle again 10 later.
  always @(posedge clk) begin
    if (mcnt == 0) begin
      if (tx_start && tx_ready) mcnt <= 1;
    end else begin
      if (mcnt == 1) rdy_m <= 1'b0;
      if (mcnt == 11) begin
        rdy_m <= 1'b1;
        mcnt  <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    ts_prev <= tx_start;
    run     <= tx_start ? run + 1 : 0;
    if (tx_start && !ts_prev) bytes.push_back(tx_data);
    if (!tx_start && ts_prev) lens.push_back(run);
    if (ram_rd_en) rd_cnt <= rd_cnt + 1;
    if (frame_done) begin
      fd_cnt   <= fd_cnt + 1;
      fd_bytes <= bytes.size();
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      tick(1);
      n++;
    end
    chk(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_bytes(input string tag, input int tgt);
    int n = 0;
    while (bytes.size() < tgt && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, {31'b0, bytes.size() >= tgt}, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_nbytes"}, bytes.size() - b0, NB);
    for (int i = 0; i < NB; i++) begin
      if (b0 + i < bytes.size())
        chk($sformatf("%s_b%0d", tag, i), {24'b0, bytes[b0+i]},
            {24'b0, EXP_B[i]});
      if (l0 + i < lens.size())
        chk($sformatf("%s_len%0d", tag, i), lens[l0+i], 3);
    end
    chk({tag, "_rd"}, rd_cnt - r0, 4);
    chk({tag, "_fd"}, fd_cnt - f0, 1);
    chk({tag, "_fdpos"}, fd_bytes, b0 + NB);
    chk({tag, "_addr"}, {16'b0, ram_addr}, 32'd0);
  endtask

  task automatic snap();
    b0 = bytes.size();
    l0 = lens.size();
    r0 = rd_cnt;
    f0 = fd_cnt;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, {31'b0, tx_start}, 32'd0);
    chk({tag, "_rden"}, {31'b0, ram_rd_en}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_fd"}, {31'b0, frame_done}, 32'd0);
    chk({tag, "_addr"}, {16'b0, ram_addr}, 32'd0);
    chk({tag, "_txd"}, {24'b0, tx_data}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    tick(2);

    snap();
    send(8'h53);
    chk("lat_rden", {31'b0, ram_rd_en}, 32'd1);
    chk("lat_busy", {31'b0, busy}, 32'd1);
    tick(1);
    chk("lat_rden_off", {31'b0, ram_rd_en}, 32'd0);
    tick(1);
    chk("lat_txd", {24'b0, tx_data}, 32'h10);
    chk("lat_start_lo", {31'b0, tx_start}, 32'd0);
    tick(1);
    chk("lat_start", {31'b0, tx_start}, 32'd1);
    wait_idle("f1_idle");
    tick(2);
    check_frame("f1");

    snap();
    send(8'h53);
    begin
      int n = 0;
      while (lens.size() < l0 + 2 && n < 500) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("ab_reach", {31'b0, lens.size() >= l0 + 2}, 32'd1);
    end
    send(8'h58);
    wait_idle("ab_idle");
    tick(20);
    chk("ab_nbytes", bytes.size() - b0, 2);
    if (bytes.size() >= b0 + 2)
      chk("ab_b1", {24'b0, bytes[b0+1]}, 32'h20);
    chk("ab_len1", (lens.size() >= l0 + 2) ? lens[l0+1] : 0, 3);
    chk("ab_rd", rd_cnt - r0, 2);
    chk("ab_fd", fd_cnt - f0, 0);
    chk("ab_addr", {16'b0, ram_addr}, 32'd0);

    snap();
    send(8'h53);
    wait_bytes("rs_reach", b0 + 1);
    send(8'h53);
    wait_idle("rs_idle");
    tick(2);
    check_frame("rs");
    r0 = rd_cnt;
    send(8'h41);
    tick(5);
    chk("junk_busy", {31'b0, busy}, 32'd0);
    send(8'h58);
    tick(5);
    chk("idle_ab_busy", {31'b0, busy}, 32'd0);
    chk("junk_rd", rd_cnt - r0, 0);

    snap();
    hold = 1'b1;
    send(8'h53);
    tick(50);
    chk("hold_start", {31'b0, tx_start}, 32'd0);
    chk("hold_busy", {31'b0, busy}, 32'd1);
    chk("hold_nbytes", bytes.size() - b0, 0);
    chk("hold_rd", rd_cnt - r0, 1);
    hold = 1'b0;
    #1;
    chk("rel_start0", {31'b0, tx_start}, 32'd0);
    tick(1);
    chk("rel_start1", {31'b0, tx_start}, 32'd1);

    wait_bytes("rst_reach", b0 + 3);
    chk("rst_in_strobe", {31'b0, tx_start}, 32'd1);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(15);
    snap();
    send(8'h53);
    chk("re_rden", {31'b0, ram_rd_en}, 32'd1);
    chk("re_addr", {16'b0, ram_addr}, 32'd0);
    wait_idle("re_idle");
    tick(2);
    check_frame("re");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_frame_streamer.md
Name: uart_frame_streamer

Overview:
- Command-driven frame dump stage between the camera frame RAM and the UART transmitter.
- Consumes bytes decoded by the UART receiver. A start command makes it read FRAME_LEN bytes sequentially from RAM and hand each one to the UART TX side using a strobe/ready handshake. An abort command stops the dump at the next byte boundary.
- Sits downstream of the UART receive path and directly upstream of the UART transmit path, replacing the simple RX-to-TX loopback in the top level.

Parameters:
- ADDR_W, 16, RAM address width.
- FRAME_LEN, 19200, bytes per frame (160x120x8bit); legal range 1..2**ADDR_W.
- START_CMD, 8'h53, received byte that starts a dump ('S').
- ABORT_CMD, 8'h58, received byte that aborts a dump ('X').
- TX_STROBE_CYCLES, 3, number of cycles tx_start is held high per byte; must be >=1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle pulse; rx_data is valid in that cycle.
- ram_addr  out  ADDR_W  frame RAM read address.
- ram_rd_en  out  1  RAM read strobe; data returns exactly 1 cycle later.
- ram_rd_data  in  8  RAM read data.
- tx_data  out  8  byte to the UART transmitter; held stable from strobe start until tx_ready rises again.
- tx_start  out  1  transmit request strobe.
- tx_ready  in  1  high when the UART transmitter is idle.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a full frame has been sent.

Behaviour:
- Reset: state=IDLE. ram_addr, tx_data and the checksum register are 0. ram_rd_en, tx_start, busy and frame_done are 0. Reset takes effect immediately at any point, including mid-byte; the in-flight byte is abandoned.
- States: IDLE, RD_REQ, RD_CAP, TX_WAIT_RDY, TX_STROBE, TX_ACK, TX_DONE.
- IDLE -> RD_REQ: on rx_valid && rx_data==START_CMD, with ram_addr set to 0. All other bytes are ignored.
- RD_REQ: ram_rd_en=1 for exactly one cycle -> RD_CAP.
- RD_CAP: tx_data <= ram_rd_data; checksum += ram_rd_data (mod 256) -> TX_WAIT_RDY.
- TX_WAIT_RDY: wait for tx_ready==1 -> TX_STROBE.
- TX_STROBE: tx_start=1 for exactly TX_STROBE_CYCLES consecutive cycles -> TX_ACK.
- TX_ACK: wait for tx_ready==0 (transmitter accepted the byte) -> TX_DONE. If tx_ready is already 0 during the strobe, TX_ACK exits on its first cycle.
- TX_DONE: wait for tx_ready==1, then:
  - if ram_addr==FRAME_LEN-1: pulse frame_done, set ram_addr=0, go to IDLE;
  - otherwise: ram_addr++, go to RD_REQ.
- Latency: START received in cycle N -> ram_rd_en in N+1 -> tx_data valid in N+3 -> earliest tx_start in N+4 (tx_ready already high).
- START while busy: ignored; no restart.
- ABORT when busy:
  - in RD_REQ or RD_CAP: go to IDLE next cycle;
  - in TX_WAIT_RDY: go to IDLE without strobing;
  - in TX_STROBE, TX_ACK or TX_DONE: latch an abort flag, finish the current byte, then go to IDLE from TX_DONE.
  - In every abort case: no frame_done, ram_addr and checksum cleared to 0.
- ABORT in IDLE: no effect.
- rx_valid arriving in the same cycle as the TX_DONE->IDLE transition: the byte is evaluated against the current (busy) state, so it is not acted on as an IDLE command.
- FRAME_LEN==1: exactly one byte is sent, then frame_done.
- Checksum is cleared at every START.

Optional Feature:
- Macro: UART_FRAME_STREAMER_CHECKSUM_EN.
- Defined: after the last data byte's TX_DONE, one extra byte tx_data=checksum (8-bit sum of all frame bytes, mod 256) is sent through TX_WAIT_RDY/TX_STROBE/TX_ACK/TX_DONE. frame_done pulses after that byte's TX_DONE. ABORT during the checksum byte follows the TX-state abort rule.
- Undefined: no trailer byte and no checksum register; frame_done follows the last data byte.

Decomposition:
- Shared package uart_cam_pkg: state enum, START_CMD/ABORT_CMD defaults, frame geometry constants (width 160, height 120, FRAME_LEN).
- One natural sub-module: uart_tx_handshake. It owns TX_WAIT_RDY/TX_STROBE/TX_ACK/TX_DONE, the strobe counter and the abort-at-boundary flag, with a byte_go in / byte_sent out interface. The parent owns RAM sequencing, command decode and the checksum.

Test Plan:
- FRAME_LEN=4, RAM={8'h10,8'h20,8'h30,8'h40}, tx_ready model drops 2 cycles after the strobe and rises 10 cycles later, send 8'h53 -> tx_data sequence 10,20,30,40; each tx_start high exactly 3 cycles; one frame_done; busy low afterwards.
- Same stimulus with UART_FRAME_STREAMER_CHECKSUM_EN defined -> fifth byte 8'hA0, and frame_done only after it.
- Send 8'h58 while the second byte is in TX_ACK -> byte 8'h20 completes; no third ram_rd_en; no frame_done; ram_addr==0.
- Send 8'h53 during a dump, then an unrelated byte 8'h41 in IDLE -> neither causes a restart or any RAM read.
- Hold tx_ready=0 for 50 cycles after START -> tx_start stays 0 and the FSM stays in TX_WAIT_RDY; it strobes 1 cycle after tx_ready rises.
- Assert rst during TX_STROBE of byte 3 -> all outputs 0 in the same cycle; a new 8'h53 restarts the dump at address 0.
